// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode, direction and state definitions for the shift sequencer
package shift_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    function automatic logic [1:0] shift_mode(input logic dir);
        return (dir == DIR_LEFT) ? MODE_LEFT : MODE_RIGHT;
    endfunction

endpackage

// File: rtl/shift_reg.sv
// rtl/shift_reg.sv - 8-bit universal shift register (hold / right / left / load), no reset
module shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_serial,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        case (i_mode)
            MODE_LOAD:  r_q <= i_data;
            MODE_RIGHT: r_q <= {i_serial, r_q[WIDTH-1:1]};
            MODE_LEFT:  r_q <= {r_q[WIDTH-2:0], i_serial};
            default:    r_q <= r_q;
        endcase
    end

    assign o_data = r_q;

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - sequencer plus the shift register it drives, as one end-to-end block
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    logic [1:0]       w_s;
    logic [WIDTH-1:0] w_i;
    logic             w_r;
    logic [WIDTH-1:0] w_sr_o;

    shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_fill  (cmd_fill),
        .cmd_count (cmd_count),
        .s         (w_s),
        .i         (w_i),
        .r         (w_r),
        .sr_o      (w_sr_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk      (clk),
        .i_mode   (w_s),
        .i_data   (w_i),
        .i_serial (w_r),
        .o_data   (w_sr_o)
    );

endmodule

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - command sequencer: load a byte, shift it N times, return the result
module shift_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] i,
    output logic             r,
    input  logic [WIDTH-1:0] sr_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             r_fill;
    logic [CNT_W-1:0] r_remaining;
    logic [1:0]       r_s;
    logic [WIDTH-1:0] r_i;
    logic             r_r;
    logic [WIDTH-1:0] r_res_data;
    logic [CNT_W-1:0] w_count_clamped;

    assign w_count_clamped = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;

    // s/i/r are loaded with the values belonging to the state being entered,
    // so the shift register sees them for exactly the cycle that state lasts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_dir       <= 1'b0;
            r_fill      <= 1'b0;
            r_remaining <= '0;
            r_s         <= MODE_HOLD;
            r_i         <= '0;
            r_r         <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_data      <= cmd_data;
                        r_dir       <= cmd_dir;
                        r_fill      <= cmd_fill;
                        r_remaining <= w_count_clamped;
                        r_s         <= MODE_LOAD;
                        r_i         <= cmd_data;
                        r_r         <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_remaining != '0) begin
                        r_s     <= shift_mode(r_dir);
                        r_r     <= r_fill;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_s     <= MODE_HOLD;
                        r_r     <= 1'b0;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_SHIFT: begin
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        r_s     <= MODE_HOLD;
                        r_r     <= 1'b0;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_res_data <= sr_o;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        r_i     <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_s     <= MODE_HOLD;
                    r_i     <= '0;
                    r_r     <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s         = r_s;
    assign i         = r_i;
    assign r         = r_r;
    assign res_data  = r_res_data;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_state == ST_RESP);

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
- Command sequencer directly upstream of the 8-bit universal shift register. It drives that register's mode, parallel-data and serial-in lines, and reads back its parallel output.
- It accepts one command per valid/ready handshake: load a byte, then shift it N times left or right with a chosen fill bit.
- After the last shift it captures the register contents and returns them on a valid/ready result port.
- Replaces hand-sequenced s/i/r stimulus with a deterministic, countable operation.

Parameters:
- WIDTH, 8, data width of the shift register and of the command/result data.
- CNT_W, 4, width of the shift-count field. Counts above WIDTH are clamped to WIDTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_data  in  WIDTH  byte to parallel-load.
- cmd_dir  in  1  0 = shift right, 1 = shift left.
- cmd_fill  in  1  serial bit fed into the vacated position on every shift.
- cmd_count  in  CNT_W  number of shifts, 0..WIDTH after clamping.
- s  out  2  shift-register mode: 00 hold, 01 right, 10 left, 11 load.
- i  out  WIDTH  shift-register parallel input.
- r  out  1  shift-register serial input.
- sr_o  in  WIDTH  shift-register parallel output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured register value.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Shift-register contract: on the rising edge,
  - s=11 loads i;
  - s=01 gives o <= {r, o[WIDTH-1:1]};
  - s=10 gives o <= {o[WIDTH-2:0], r};
  - s=00 holds.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, RESP. All outputs are registered or decoded from registered state only; there is no combinational path from cmd_* or res_ready to s/i/r.
- IDLE:
  - cmd_ready=1, s=00, i=0, r=0.
  - On cmd_valid&cmd_ready: latch data, dir, fill and min(count, WIDTH) into internal registers, then go to LOAD.
- LOAD:
  - s=11, i=latched data, r=0.
  - Next state: SHIFT if remaining>0, else CAPTURE.
- SHIFT:
  - s=01 if dir=0, s=10 if dir=1; r=latched fill; i holds latched data.
  - remaining decrements every cycle. When remaining==1, next state is CAPTURE.
- CAPTURE:
  - s=00.
  - On the next edge, res_data <= sr_o, then go to RESP.
- RESP:
  - res_valid=1, s=00.
  - On res_ready: go to IDLE, and res_valid drops on that edge.
  - res_data is stable while res_valid=1.
- Latency: accept on edge E0 gives res_valid high after edge E(N+2), where N is the clamped count. The register loads at E1 and shifts at E2..E(N+1).
- cmd_ready is 0 outside IDLE. Commands presented while busy are not accepted and must be held by the source.
- res_ready with res_valid=0 is ignored.
- Reset (asynchronous, active-low), including mid-operation:
  - state=IDLE, remaining=0, all latched fields=0;
  - outputs: s=00, i=0, r=0, res_valid=0, res_data=0, busy=0;
  - cmd_ready=1 after release.
  - The downstream register is not cleared by this block.
- Reset release: the first command may be accepted on the first rising edge with reset=1.
- Count clamp: cmd_count > WIDTH is treated as WIDTH. cmd_count=0 performs load then capture, so res_data equals cmd_data.
- Back-to-back: the next command is accepted in the IDLE cycle that follows the RESP handshake edge. Minimum period is N+4 cycles.

Decomposition:
- Shared package shift_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_RIGHT=2'b01, MODE_LEFT=2'b10, MODE_LOAD=2'b11;
  - state encoding typedef for IDLE/LOAD/SHIFT/CAPTURE/RESP;
  - DIR_RIGHT=0, DIR_LEFT=1.
- No sub-module inside shift_ctrl.
- A top-level wrapper shift_unit instantiates shift_ctrl and the shift register together and is the bench's DUT for end-to-end checks.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> s=00, i=0, r=0, res_valid=0, busy=0, cmd_ready=1. Assert reset=0 during SHIFT -> same values immediately, without waiting for a clock edge.
- Right shift: data=10110011, dir=0, fill=1, count=2 -> s sequence 11,01,01,00; res_data=11101100; res_valid rises 4 edges after accept.
- Left shift: data=10110011, dir=1, fill=1, count=3 -> res_data=10011111; res_valid 5 edges after accept.
- Zero count and clamp:
  - count=0, data=0x5A -> res_data=0x5A after 2 edges.
  - count=12, dir=0, fill=0, data=0xFF -> exactly 8 shift cycles, res_data=0x00.
- Handshake stalls:
  - hold res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0.
  - assert cmd_valid while busy -> not accepted; accepted in the first IDLE cycle after the res handshake.
- Back-to-back: two commands with cmd_valid held high, results 0xB3 (count 0) then 0x59 (count 1, right, fill 0) -> correct order, no lost or duplicated result.
